// File: rtl/batched_tensor_core.sv
// batched_tensor_core
//   Small tensor unit operating on DIM x DIM signed matrices. An accepted start
//   copies both operands into internal snapshot registers. The unit then produces
//   LANES result elements per clock in row-major order until the full matrix is
//   written. Results land in a registered output matrix. Elements not yet written
//   keep their previous values.
//
//   Opcodes: 000 matmul, 001 add, 010 ReLU(A), 011 subtract, 100 transpose(A).
//   An opcode of 101..111 skips RUN, goes straight to DONE and raises op_error.
//
// Configuration macro:
//   TENSOR_CORE_SATURATE_EN  defined   -> results are clamped to the signed
//                                         DATA_WIDTH range
//                            undefined -> results keep their low DATA_WIDTH bits
//                                         (two's-complement wrap)
//
// Ports:
//   tensor_core_clock                       sole clock, rising edge
//   reset_in                                synchronous active-high reset
//   tensor_core_register_file_write_enable  abort: drops RUN and blocks start
//   should_start_tensor_core                level-sampled start request
//   operation_select[2:0]                   opcode, latched on acceptance
//   tensor_core_input1/2[DIM][DIM]          operands A and B
//   tensor_core_output[DIM][DIM]            registered result C
//   busy                                    high while in RUN
//   done                                    one-cycle pulse in DONE
//   op_error                                sticky unsupported-opcode flag
module batched_tensor_core #(
    parameter int DIM        = 3,
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 1
) (
    input  logic                         tensor_core_clock,
    input  logic                         reset_in,
    input  logic                         tensor_core_register_file_write_enable,
    input  logic                         should_start_tensor_core,
    input  logic [2:0]                   operation_select,
    input  logic signed [DATA_WIDTH-1:0] tensor_core_input1 [DIM][DIM],
    input  logic signed [DATA_WIDTH-1:0] tensor_core_input2 [DIM][DIM],
    output logic signed [DATA_WIDTH-1:0] tensor_core_output [DIM][DIM],
    output logic                         busy,
    output logic                         done,
    output logic                         op_error
);

    localparam int N     = DIM * DIM;
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(DIM);
    localparam int IDX_W = $clog2(N + LANES + 1);
    localparam int RC_W  = $clog2(DIM);

    localparam logic [2:0] OP_MATMUL    = 3'b000;
    localparam logic [2:0] OP_ADD       = 3'b001;
    localparam logic [2:0] OP_RELU      = 3'b010;
    localparam logic [2:0] OP_SUB       = 3'b011;
    localparam logic [2:0] OP_TRANSPOSE = 3'b100;

`ifdef TENSOR_CORE_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [2:0]                  op_q, op_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [IDX_W-1:0]            idx_nxt;
    logic                        err_q, err_d;
    logic                        accept;
    logic                        run_wr;
    logic                        last;
    logic                        abort;

    logic signed [DATA_WIDTH-1:0] a_q [DIM][DIM];
    logic signed [DATA_WIDTH-1:0] b_q [DIM][DIM];
    logic signed [DATA_WIDTH-1:0] c_q [DIM][DIM];
    logic signed [DATA_WIDTH-1:0] c_d [DIM][DIM];

    assign abort   = tensor_core_register_file_write_enable;
    assign idx_nxt = idx_q + IDX_W'(LANES);
    assign last    = (idx_nxt >= IDX_W'(N));

    // Reduce a wide accumulator to one output element.
    function automatic logic signed [DATA_WIDTH-1:0] fit(input logic signed [ACC_W-1:0] v);
`ifdef TENSOR_CORE_SATURATE_EN
        if (v > SAT_MAX) begin
            return SAT_MAX[DATA_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[DATA_WIDTH-1:0];
        end
        return v[DATA_WIDTH-1:0];
`else
        return v[DATA_WIDTH-1:0];
`endif
    endfunction

    // Next-state logic. DONE behaves like IDLE for start acceptance. Abort wins
    // over start, and in RUN it drops back to IDLE without writing anything.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        err_d   = err_q;
        accept  = 1'b0;
        run_wr  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (should_start_tensor_core && !abort) begin
                    accept = 1'b1;
                    op_d   = operation_select;
                    idx_d  = '0;
                    if (operation_select > OP_TRANSPOSE) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        err_d   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    run_wr = 1'b1;
                    idx_d  = idx_nxt;
                    if (last) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane datapath: each lane computes one element from the snapshot registers.
    // Lanes that fall past the last element leave c_d untouched.
    always_comb begin : lane_datapath
        logic [IDX_W-1:0]        lane_idx;
        logic [RC_W-1:0]         row;
        logic [RC_W-1:0]         col;
        logic signed [ACC_W-1:0] acc;
        c_d      = c_q;
        lane_idx = '0;
        row      = '0;
        col      = '0;
        acc      = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_idx = idx_q + IDX_W'(l);
            if (lane_idx < IDX_W'(N)) begin
                row = RC_W'(lane_idx / IDX_W'(DIM));
                col = RC_W'(lane_idx % IDX_W'(DIM));
                acc = '0;
                case (op_q)
                    OP_MATMUL: begin
                        for (int unsigned k = 0; k < DIM; k++) begin
                            acc = acc + ACC_W'(a_q[row][k]) * ACC_W'(b_q[k][col]);
                        end
                    end
                    OP_ADD:       acc = ACC_W'(a_q[row][col]) + ACC_W'(b_q[row][col]);
                    OP_RELU:      acc = a_q[row][col][DATA_WIDTH-1] ? '0 : ACC_W'(a_q[row][col]);
                    OP_SUB:       acc = ACC_W'(a_q[row][col]) - ACC_W'(b_q[row][col]);
                    OP_TRANSPOSE: acc = ACC_W'(a_q[col][row]);
                    default:      acc = '0;
                endcase
                c_d[row][col] = fit(acc);
            end
        end
    end

    always_ff @(posedge tensor_core_clock) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            c_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            if (accept) begin
                a_q <= tensor_core_input1;
                b_q <= tensor_core_input2;
            end
            if (run_wr) begin
                c_q <= c_d;
            end
        end
    end

    assign tensor_core_output = c_q;
    assign busy               = (state_q == S_RUN);
    assign done               = (state_q == S_DONE);
    assign op_error           = err_q;

endmodule

// File: tb/tb_batched_tensor_core.sv
// Directed bench for batched_tensor_core. It uses one LANES=1 instance and one
// LANES=4 instance, both with DIM=3 and DATA_WIDTH=8. Expected matrices are
// written out by hand.
module tb_batched_tensor_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic              abort1, start1, busy1, done1, err1;
    logic [2:0]        op1;
    logic signed [7:0] a1 [3][3];
    logic signed [7:0] b1 [3][3];
    logic signed [7:0] c1 [3][3];

    logic              abort4, start4, busy4, done4, err4;
    logic [2:0]        op4;
    logic signed [7:0] a4 [3][3];
    logic signed [7:0] b4 [3][3];
    logic signed [7:0] c4 [3][3];

    batched_tensor_core #(.DIM(3), .DATA_WIDTH(8), .LANES(1)) u1 (
        .tensor_core_clock                      (clk),
        .reset_in                               (rst),
        .tensor_core_register_file_write_enable (abort1),
        .should_start_tensor_core               (start1),
        .operation_select                       (op1),
        .tensor_core_input1                     (a1),
        .tensor_core_input2                     (b1),
        .tensor_core_output                     (c1),
        .busy                                   (busy1),
        .done                                   (done1),
        .op_error                               (err1)
    );

    batched_tensor_core #(.DIM(3), .DATA_WIDTH(8), .LANES(4)) u4 (
        .tensor_core_clock                      (clk),
        .reset_in                               (rst),
        .tensor_core_register_file_write_enable (abort4),
        .should_start_tensor_core               (start4),
        .operation_select                       (op4),
        .tensor_core_input1                     (a4),
        .tensor_core_input2                     (b4),
        .tensor_core_output                     (c4),
        .busy                                   (busy4),
        .done                                   (done4),
        .op_error                               (err4)
    );

`ifdef TENSOR_CORE_SATURATE_EN
    localparam int ADD100 = 127;
`else
    localparam int ADD100 = -56;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]       op;
        logic [8:0][7:0]  a;
        logic [8:0][7:0]  b;
        logic [8:0][7:0]  c;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [8:0][7:0] pk9(input int e0, input int e1, input int e2,
                                            input int e3, input int e4, input int e5,
                                            input int e6, input int e7, input int e8);
        logic [8:0][7:0] r;
        r[0] = 8'(e0); r[1] = 8'(e1); r[2] = 8'(e2);
        r[3] = 8'(e3); r[4] = 8'(e4); r[5] = 8'(e5);
        r[6] = 8'(e6); r[7] = 8'(e7); r[8] = 8'(e8);
        return r;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load1(input logic [8:0][7:0] a, input logic [8:0][7:0] b);
        for (int k = 0; k < 9; k++) begin
            a1[k/3][k%3] = a[k];
            b1[k/3][k%3] = b[k];
        end
    endtask

    task automatic chk_c1(input string tag, input logic [8:0][7:0] exp);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s_c%0d", tag, k), c1[k/3][k%3], $signed(exp[k]));
        end
    endtask

    // Called on a falling edge. Returns on the falling edge after acceptance.
    task automatic start_u1(input logic [2:0] op);
        op1    = op;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    // lat = rising edges after the acceptance edge until done is seen
    task automatic wait_done1(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done1 !== 1'b1 && lat < 40) begin
            if (busy1 === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat, bc, saw_done;

        vecs[0].op = 3'b000;
        vecs[0].a  = pk9(1, 0, 0, 0, 1, 0, 0, 0, 1);
        vecs[0].b  = pk9(1, 2, 3, 4, 5, 6, 7, 8, 9);
        vecs[0].c  = pk9(1, 2, 3, 4, 5, 6, 7, 8, 9);
        vecs[1].op = 3'b001;
        vecs[1].a  = pk9(100, 100, 100, 100, 100, 100, 100, 100, 100);
        vecs[1].b  = pk9(100, 100, 100, 100, 100, 100, 100, 100, 100);
        vecs[1].c  = pk9(ADD100, ADD100, ADD100, ADD100, ADD100, ADD100, ADD100, ADD100, ADD100);
        vecs[2].op = 3'b010;
        vecs[2].a  = pk9(-5, 7, 0, -128, 127, -1, 3, -3, 2);
        vecs[2].b  = pk9(9, 9, 9, 9, 9, 9, 9, 9, 9);
        vecs[2].c  = pk9(0, 7, 0, 0, 127, 0, 3, 0, 2);
        vecs[3].op = 3'b011;
        vecs[3].a  = pk9(10, -10, 0, 1, 2, 3, -100, 100, 50);
        vecs[3].b  = pk9(3, 5, 0, 2, -2, 3, 1, -1, -50);
        vecs[3].c  = pk9(7, -15, 0, -1, 4, 0, -101, 101, 100);
        vecs[4].op = 3'b100;
        vecs[4].a  = pk9(1, 2, 3, 4, 5, 6, 7, 8, 9);
        vecs[4].b  = pk9(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4].c  = pk9(1, 4, 7, 2, 5, 8, 3, 6, 9);
        vecs[5].op = 3'b000;
        vecs[5].a  = pk9(1, -2, 0, 3, 1, -1, 0, 2, 2);
        vecs[5].b  = pk9(2, 1, 0, -1, 3, 1, 4, 0, -2);
        vecs[5].c  = pk9(4, -5, -2, 1, 6, 3, 6, 6, -2);

        rst = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; op1 = '0;
        start4 = 1'b0; abort4 = 1'b0; op4 = '0;
        for (int k = 0; k < 9; k++) begin
            a1[k/3][k%3] = '0; b1[k/3][k%3] = '0;
            a4[k/3][k%3] = '0; b4[k/3][k%3] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_err", err1, 0);
        chk_c1("rst", '0);

        // Table of full single-lane runs
        for (int i = 0; i < 6; i++) begin
            load1(vecs[i].a, vecs[i].b);
            start_u1(vecs[i].op);
            wait_done1(lat, bc);
            chk($sformatf("v%0d_latency", i), lat, 9);
            chk($sformatf("v%0d_busy_cycles", i), bc, 9);
            chk($sformatf("v%0d_err", i), err1, 0);
            chk_c1($sformatf("v%0d", i), vecs[i].c);
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), done1, 0);
        end

        // Unsupported opcode, then a valid transpose clears the error flag
        load1(pk9(1, 2, 3, 4, 5, 6, 7, 8, 9), pk9(0, 0, 0, 0, 0, 0, 0, 0, 0));
        start_u1(3'b111);
        chk("bad_done", done1, 1);
        chk("bad_busy", busy1, 0);
        chk("bad_err", err1, 1);
        chk_c1("bad_keep", vecs[5].c);
        @(negedge clk);
        chk("bad_done_clear", done1, 0);
        chk("bad_err_sticky", err1, 1);
        load1(pk9(1, -2, 3, -4, 5, -6, 7, -8, 9), pk9(0, 0, 0, 0, 0, 0, 0, 0, 0));
        start_u1(3'b100);
        wait_done1(lat, bc);
        chk("tr_latency", lat, 9);
        chk("tr_err", err1, 0);
        chk_c1("tr", pk9(1, -4, 7, -2, 5, -8, 3, -6, 9));
        @(negedge clk);

        // Abort beats start in IDLE
        op1 = 3'b001; start1 = 1'b1; abort1 = 1'b1;
        @(negedge clk);
        chk("abort_blocks_start", busy1, 0);
        start1 = 1'b0; abort1 = 1'b0;
        @(negedge clk);

        // Abort on the 4th RUN edge of a matmul
        load1(pk9(1, 0, 0, 0, 1, 0, 0, 0, 1), pk9(10, 11, 12, 13, 14, 15, 16, 17, 18));
        start_u1(3'b000);
        repeat (3) @(negedge clk);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        chk_c1("abort", pk9(10, 11, 12, -2, 5, -8, 3, -6, 9));
        saw_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done1 !== 1'b0) saw_done = 1;
        end
        chk("abort_no_done", saw_done, 0);

        // Four lanes: ReLU finishes in 3 RUN cycles
        for (int k = 0; k < 9; k++) a4[k/3][k%3] = 8'(k);
        a4[0][0] = -5; a4[0][1] = 7;  a4[0][2] = 0;
        a4[1][0] = 1;  a4[1][1] = -2; a4[1][2] = 3;
        a4[2][0] = -4; a4[2][1] = 5;  a4[2][2] = 6;
        op4 = 3'b010; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        a4[2][2] = -99;
        chk("l4_busy_c0", busy4, 1);
        @(negedge clk);
        chk("l4_e1_c10", c4[1][0], 1);
        chk("l4_e1_c21", c4[2][1], 0);
        @(negedge clk);
        chk("l4_e2_c21", c4[2][1], 5);
        chk("l4_e2_c22", c4[2][2], 0);
        chk("l4_e2_busy", busy4, 1);
        @(negedge clk);
        chk("l4_e3_c22", c4[2][2], 6);
        chk("l4_e3_done", done4, 1);
        chk("l4_e3_busy", busy4, 0);
        chk("l4_r0c0", c4[0][0], 0);
        chk("l4_r0c1", c4[0][1], 7);
        chk("l4_r0c2", c4[0][2], 0);
        chk("l4_r1c1", c4[1][1], 0);
        chk("l4_r2c0", c4[2][0], 0);
        @(negedge clk);
        chk("l4_done_one_cycle", done4, 0);

        // Start held high: rerun accepted from DONE, then reset mid-run
        load1(pk9(1, 2, 3, 4, 5, 6, 7, 8, 9), pk9(1, 1, 1, 1, 1, 1, 1, 1, 1));
        op1 = 3'b001; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done1(lat, bc);
        chk("hold_latency", lat, 9);
        chk_c1("hold_run1", pk9(2, 3, 4, 5, 6, 7, 8, 9, 10));
        load1(pk9(1, 2, 3, 4, 5, 6, 7, 8, 9), pk9(2, 2, 2, 2, 2, 2, 2, 2, 2));
        @(negedge clk);
        chk("hold_rerun_busy", busy1, 1);
        chk("hold_rerun_done", done1, 0);
        repeat (2) @(negedge clk);
        chk("hold_run2_c0", c1[0][0], 3);
        chk("hold_run2_c1", c1[0][1], 4);
        chk("hold_run2_c2", c1[0][2], 4);
        rst = 1'b1; start1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy1, 0);
        chk("midrst_done", done1, 0);
        chk("midrst_err", err1, 0);
        chk_c1("midrst", '0);
        @(negedge clk);
        chk("midrst_stays_idle", busy1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
